// File: rtl/rvfi_mon_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rvfi_mon_pkg : shared types and constants for the RVFI commit monitor
// Revision     : 1.0
// ----------------------------------------------------------------------------
package rvfi_mon_pkg;

  localparam int ERR_ORDER    = 0;
  localparam int ERR_LANE     = 1;
  localparam int ERR_POSTHALT = 2;
  localparam int ERR_WDOG     = 3;
  localparam int ERR_X        = 4;
  localparam int ERR_W        = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } win_state_e;

  localparam logic [31:0] INST_START    = 32'h00102013;
  localparam logic [31:0] INST_STOP     = 32'h00202013;
  localparam logic [31:0] INST_BEQ_SELF = 32'h00000063;
  localparam logic [31:0] INST_JAL_SELF = 32'h0000006f;

  // A retired instruction that jumps to itself means the core has parked.
  function automatic logic is_halt(input logic [31:0] inst,
                                   input logic [31:0] pc_rdata,
                                   input logic [31:0] pc_wdata);
    return (pc_rdata == pc_wdata) || (inst == INST_BEQ_SELF) ||
           (inst == INST_JAL_SELF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rvfi_lane_check.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rvfi_lane_check : combinational per-cycle decode of the retire lanes
// Revision        : 1.0
// ----------------------------------------------------------------------------
module rvfi_lane_check
  import rvfi_mon_pkg::*;
#(
  parameter int NRET    = 2,
  parameter int ORDER_W = 64,
  parameter int N_W     = $clog2(NRET + 1)
) (
  input  logic [NRET-1:0]         valid_i,
  input  logic [NRET*ORDER_W-1:0] order_i,
  input  logic [NRET*32-1:0]      inst_i,
  input  logic [NRET*32-1:0]      pc_rdata_i,
  input  logic [NRET*32-1:0]      pc_wdata_i,
  input  logic [ORDER_W-1:0]      exp_order_i,
  output logic [N_W-1:0]          n_o,
  output logic                    packed_ok_o,
  output logic [NRET-1:0]         order_ok_o,
  output logic [NRET-1:0]         halt_1h_o,
  output logic                    start_hit_o,
  output logic                    stop_hit_o
);

  always_comb begin : p_decode
    logic prefix;
    logic seen_halt;
    n_o         = '0;
    packed_ok_o = 1'b1;
    order_ok_o  = '1;
    halt_1h_o   = '0;
    start_hit_o = 1'b0;
    stop_hit_o  = 1'b0;
    prefix      = 1'b1;
    seen_halt   = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      n_o    = n_o + N_W'(valid_i[i]);
      // Only the unbroken run of valid lanes from lane 0 is order-checked.
      prefix = prefix & valid_i[i];
      if (prefix && (order_i[i*ORDER_W +: ORDER_W] != exp_order_i + ORDER_W'(i)))
        order_ok_o[i] = 1'b0;
      if (valid_i[i] && !seen_halt &&
          is_halt(inst_i[i*32 +: 32], pc_rdata_i[i*32 +: 32], pc_wdata_i[i*32 +: 32])) begin
        halt_1h_o[i] = 1'b1;
        seen_halt    = 1'b1;
      end
      if (valid_i[i] && (inst_i[i*32 +: 32] == INST_START)) start_hit_o = 1'b1;
      if (valid_i[i] && (inst_i[i*32 +: 32] == INST_STOP))  stop_hit_o  = 1'b1;
    end
    for (int i = 1; i < NRET; i++) begin
      if (valid_i[i] && !valid_i[i-1]) packed_ok_o = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rvfi_commit_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rvfi_commit_monitor : multi-retire RVFI order/halt/watchdog/IPC checker
// Revision            : 1.0
// ----------------------------------------------------------------------------
module rvfi_commit_monitor
  import rvfi_mon_pkg::*;
#(
  parameter int NRET    = 2,
  parameter int ORDER_W = 64,
  parameter int CNT_W   = 64,
  parameter int TIMEOUT = 10000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRET-1:0]         valid_i,
  input  logic [NRET*ORDER_W-1:0] order_i,
  input  logic [NRET*32-1:0]      inst_i,
  input  logic [NRET*32-1:0]      pc_rdata_i,
  input  logic [NRET*32-1:0]      pc_wdata_i,
  output logic                    halt_o,
  output logic                    error_o,
  output logic [ERR_W-1:0]        err_code_o,
  output logic [1:0]              win_state_o,
  output logic [CNT_W-1:0]        inst_count_o,
  output logic [CNT_W-1:0]        cycle_count_o
);

  localparam int N_W  = $clog2(NRET + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  logic [N_W-1:0]     w_n;
  logic               w_packed_ok;
  logic [NRET-1:0]    w_order_ok;
  logic [NRET-1:0]    w_halt_1h;
  logic               w_start;
  logic               w_stop;
  logic               w_post_halt;
  logic               w_x;

  logic [ORDER_W-1:0] exp_q;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               halt_q;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               error_q;
  win_state_e         state_q, state_d;
  logic [CNT_W-1:0]   inst_q, inst_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  rvfi_lane_check #(
    .NRET    (NRET),
    .ORDER_W (ORDER_W),
    .N_W     (N_W)
  ) u_lane_check (
    .valid_i     (valid_i),
    .order_i     (order_i),
    .inst_i      (inst_i),
    .pc_rdata_i  (pc_rdata_i),
    .pc_wdata_i  (pc_wdata_i),
    .exp_order_i (exp_q),
    .n_o         (w_n),
    .packed_ok_o (w_packed_ok),
    .order_ok_o  (w_order_ok),
    .halt_1h_o   (w_halt_1h),
    .start_hit_o (w_start),
    .stop_hit_o  (w_stop)
  );

  // Commits after an earlier halt, or in lanes above this cycle's halting lane.
  always_comb begin
    w_post_halt = halt_q && (w_n != '0);
    for (int i = 1; i < NRET; i++) begin
      for (int j = 0; j < i; j++) begin
        if (w_halt_1h[j] && valid_i[i]) w_post_halt = 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  always_comb begin
    w_x = $isunknown(valid_i);
    for (int i = 0; i < NRET; i++) begin
      if (valid_i[i] && ($isunknown(order_i[i*ORDER_W +: ORDER_W]) ||
                         $isunknown(inst_i[i*32 +: 32]) ||
                         $isunknown(pc_rdata_i[i*32 +: 32]) ||
                         $isunknown(pc_wdata_i[i*32 +: 32])))
        w_x = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_x) $error("rvfi_commit_monitor: unknown value on retire bus");
  end
`else
  assign w_x = 1'b0;
`endif

  always_comb begin
    wd_d = wd_q;
    if (!halt_q) begin
      if (w_n != '0)          wd_d = '0;
      else if (wd_q != WD_MAX) wd_d = wd_q + WD_W'(1);
    end
  end

  always_comb begin
    err_d               = err_q;
    err_d[ERR_ORDER]    = err_q[ERR_ORDER]    | ~(&w_order_ok);
    err_d[ERR_LANE]     = err_q[ERR_LANE]     | ~w_packed_ok;
    err_d[ERR_POSTHALT] = err_q[ERR_POSTHALT] | w_post_halt;
    err_d[ERR_WDOG]     = err_q[ERR_WDOG]     | (!halt_q && (wd_d == WD_MAX));
    err_d[ERR_X]        = err_q[ERR_X]        | w_x;
  end

  // A start marker restarts the window and drops its own cycle's commits.
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    cyc_d   = cyc_q;
    case (state_q)
      IDLE, MEASURE: begin
        if (w_start) begin
          state_d = MEASURE;
          inst_d  = '0;
          cyc_d   = '0;
        end else begin
          cyc_d  = sat_add(cyc_q, CNT_W'(1));
          inst_d = sat_add(inst_q, CNT_W'(w_n));
          if ((state_q == MEASURE) && w_stop) state_d = DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q   <= '0;
      wd_q    <= '0;
      halt_q  <= 1'b0;
      err_q   <= '0;
      error_q <= 1'b0;
      inst_q  <= '0;
      cyc_q   <= '0;
    end else begin
      exp_q   <= exp_q + ORDER_W'(w_n);
      wd_q    <= wd_d;
      halt_q  <= halt_q | (|w_halt_1h);
      err_q   <= err_d;
      error_q <= |err_d;
      inst_q  <= inst_d;
      cyc_q   <= cyc_d;
    end
  end

  assign halt_o        = halt_q;
  assign error_o       = error_q;
  assign err_code_o    = err_q;
  assign win_state_o   = state_q;
  assign inst_count_o  = inst_q;
  assign cycle_count_o = cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_rvfi_commit_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rvfi_commit_monitor : directed bench with a lane-level reference model
// Revision               : 1.0
// ----------------------------------------------------------------------------
module tb_rvfi_commit_monitor;

  localparam int NRET = 2;
  localparam int TO   = 16;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] START = 32'h00102013;
  localparam logic [31:0] STOP  = 32'h00202013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NRET-1:0] valid;
  logic [63:0] ord [NRET];
  logic [31:0] ins [NRET];
  logic [31:0] pcr [NRET];
  logic [31:0] pcw [NRET];

  logic halt_o, error_o;
  logic [4:0] err_code_o;
  logic [1:0] win_state_o;
  logic [63:0] inst_count_o, cycle_count_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rvfi_commit_monitor #(
    .NRET(NRET), .ORDER_W(64), .CNT_W(64), .TIMEOUT(TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid),
    .order_i       ({ord[1], ord[0]}),
    .inst_i        ({ins[1], ins[0]}),
    .pc_rdata_i    ({pcr[1], pcr[0]}),
    .pc_wdata_i    ({pcw[1], pcw[0]}),
    .halt_o        (halt_o),
    .error_o       (error_o),
    .err_code_o    (err_code_o),
    .win_state_o   (win_state_o),
    .inst_count_o  (inst_count_o),
    .cycle_count_o (cycle_count_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lane-index arithmetic on the current inputs.
  logic [63:0] m_exp, m_inst, m_cyc;
  int          m_wd, m_st, mn, mf, mh;
  logic        m_halt, m_start, m_stop, m_post;
  logic [4:0]  m_err;

  always @(posedge clk) begin
    if (rst) begin
      m_exp = 0; m_wd = 0; m_halt = 0; m_err = 0; m_st = 0; m_inst = 0; m_cyc = 0;
    end else begin
      mn = 0; mf = NRET; mh = -1; m_start = 0; m_stop = 0;
      for (int i = 0; i < NRET; i++) begin
        if (valid[i]) mn++;
        else if (mf == NRET) mf = i;
        if (valid[i] && mh < 0 &&
            (pcr[i] == pcw[i] || ins[i] == 32'h63 || ins[i] == 32'h6f)) mh = i;
        if (valid[i] && ins[i] == START) m_start = 1;
        if (valid[i] && ins[i] == STOP)  m_stop  = 1;
      end
      for (int i = 0; i < NRET; i++) begin
        if (i > mf && valid[i]) m_err[1] = 1;
        if (i < mf && ord[i] != m_exp + 64'(i)) m_err[0] = 1;
      end
      m_post = m_halt && mn > 0;
      if (mh >= 0)
        for (int i = 0; i < NRET; i++) if (i > mh && valid[i]) m_post = 1;
      if (m_post) m_err[2] = 1;
      if (!m_halt) begin
        if (mn > 0) m_wd = 0;
        else if (m_wd < TO) m_wd++;
        if (m_wd == TO) m_err[3] = 1;
      end
      if (m_st != 2) begin
        if (m_start) begin
          m_st = 1; m_inst = 0; m_cyc = 0;
        end else begin
          if (m_cyc != '1) m_cyc = m_cyc + 1;
          m_inst = (m_inst > ~64'(mn)) ? '1 : m_inst + 64'(mn);
          if (m_st == 1 && m_stop) m_st = 2;
        end
      end
      m_exp = m_exp + 64'(mn);
      if (mh >= 0) m_halt = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("halt", 64'(halt_o), 64'(m_halt));
      check("error", 64'(error_o), 64'(|m_err));
      check("err_code", 64'(err_code_o), 64'(m_err));
      check("win_state", 64'(win_state_o), 64'(m_st));
      check("inst_count", inst_count_o, m_inst);
      check("cycle_count", cycle_count_o, m_cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input int i, input logic v, input logic [63:0] o, input logic [31:0] in);
    valid[i] = v;
    ord[i]   = o;
    ins[i]   = in;
    pcr[i]   = 32'h1000 + (o[31:0] << 2);
    pcw[i]   = pcr[i] + 32'd4;
  endtask

  task automatic idle();
    for (int i = 0; i < NRET; i++) lane(i, 1'b0, 64'd0, NOP);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    do_reset();
    check("rst_err", 64'(err_code_o), 64'd0);
    check("rst_halt", 64'(halt_o), 64'd0);
    check("rst_state", 64'(win_state_o), 64'd0);
    check("rst_inst", inst_count_o, 64'd0);
    check("rst_cyc", cycle_count_o, 64'd0);

    // In-order dual/single commits
    lane(0, 1, 0, NOP); lane(1, 1, 1, NOP); step();
    lane(0, 1, 2, NOP); lane(1, 1, 3, NOP); step();
    lane(0, 1, 4, NOP); lane(1, 0, 0, NOP); step();
    check("t1_err", 64'(err_code_o), 64'd0);
    check("t1_inst", inst_count_o, 64'd5);
    check("t1_cyc", cycle_count_o, 64'd3);
    lane(0, 1, 5, NOP); lane(1, 1, 6, NOP); step();
    check("t1_exp5", 64'(err_code_o), 64'd0);
    check("t1_inst2", inst_count_o, 64'd7);
    idle(); step();

    // Order mismatch stays sticky, no cascade
    do_reset();
    lane(0, 1, 0, NOP); lane(1, 1, 1, NOP); step();
    lane(0, 1, 2, NOP); lane(1, 1, 7, NOP); step();
    check("t2_order", 64'(err_code_o), 64'h01);
    lane(0, 1, 4, NOP); lane(1, 1, 5, NOP); step();
    check("t2_sticky", 64'(err_code_o), 64'h01);
    idle(); step();

    // Non-packed lanes, lane 1 order ignored, exp still advances by n
    do_reset();
    lane(0, 0, 0, NOP); lane(1, 1, 99, NOP); step();
    check("t3_lane", 64'(err_code_o), 64'h02);
    lane(0, 1, 1, NOP); lane(1, 0, 0, NOP); step();
    check("t3_exp", 64'(err_code_o), 64'h02);
    idle(); step();

    // Halt in lane 0 with lane 1 also committing; watchdog frozen afterwards
    do_reset();
    lane(0, 1, 0, 32'h0000006f); lane(1, 1, 1, NOP); step();
    check("t4_halt", 64'(halt_o), 64'd1);
    check("t4_post", 64'(err_code_o), 64'h04);
    idle();
    repeat (20000) step();
    check("t4_nowdog", 64'(err_code_o), 64'h04);

    // Halt via pc_rdata == pc_wdata, then a later commit
    do_reset();
    check("t4b_rst_halt", 64'(halt_o), 64'd0);
    lane(0, 1, 0, NOP); pcw[0] = pcr[0]; step();
    check("t4b_halt", 64'(halt_o), 64'd1);
    check("t4b_err0", 64'(err_code_o), 64'd0);
    idle(); step();
    lane(0, 1, 1, NOP); step();
    check("t4b_post", 64'(err_code_o), 64'h04);
    idle(); step();

    // Watchdog fires exactly TO cycles after reset release
    do_reset();
    repeat (TO - 1) step();
    check("t5_early", 64'(err_code_o), 64'd0);
    step();
    check("t5_wdog", 64'(err_code_o), 64'h08);
    check("t5_error", 64'(error_o), 64'd1);

    // IPC window
    do_reset();
    check("t6_rst_state", 64'(win_state_o), 64'd0);
    check("t6_rst_cyc", cycle_count_o, 64'd0);
    repeat (9) step();
    lane(0, 1, 0, START); step();
    check("t6_start_st", 64'(win_state_o), 64'd1);
    check("t6_start_cyc", cycle_count_o, 64'd0);
    for (int k = 0; k < 4; k++) begin
      lane(0, 1, 64'(1 + 2*k), NOP); lane(1, 1, 64'(2 + 2*k), NOP); step();
    end
    lane(0, 1, 9, STOP); lane(1, 0, 0, NOP); step();
    check("t6_inst", inst_count_o, 64'd9);
    check("t6_cyc", cycle_count_o, 64'd5);
    check("t6_done", 64'(win_state_o), 64'd2);
    lane(0, 1, 10, START); step();
    check("t6_frz_inst", inst_count_o, 64'd9);
    check("t6_frz_cyc", cycle_count_o, 64'd5);
    check("t6_frz_st", 64'(win_state_o), 64'd2);
    idle(); step();

    // Start and stop together: start wins
    do_reset();
    lane(0, 1, 0, START); lane(1, 1, 1, STOP); step();
    check("t7_st", 64'(win_state_o), 64'd1);
    check("t7_inst0", inst_count_o, 64'd0);
    lane(0, 1, 2, NOP); lane(1, 0, 0, NOP); step();
    check("t7_inst1", inst_count_o, 64'd1);
    check("t7_cyc1", cycle_count_o, 64'd1);
    check("t7_st2", 64'(win_state_o), 64'd1);
    idle(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
